// File: rtl/axis_pkg.sv
// axis_pkg: shared arbiter state type, index-width helper and packet counter width
package axis_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam int PKT_CNT_W = 16;
  function automatic int idx_w(int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axis_rr_picker.sv
// axis_rr_picker: rotate-priority encoder, the first request after ptr (mod NUM_SRC) wins
module axis_rr_picker
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);
  assign any = |req;
  // scan from the farthest slot to the nearest so the nearest request after ptr overrides
  always_comb begin
    idx = '0;
    for (int k = NUM_SRC; k >= 1; k--)
      if (req[IDX_W'((int'(ptr) + k) % NUM_SRC)]) idx = IDX_W'((int'(ptr) + k) % NUM_SRC);
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin AXI4-Stream arbiter, NUM_SRC slaves onto one master.
// Optional AXIS_ARB_TID_TAG_EN: low IDX_W bits of m_tid carry the granted source index.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 1,
  localparam int KEEP_STRB_W = DATA_W / 8,
  localparam int IDX_W = idx_w(NUM_SRC)
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_SRC-1:0]              s_tvalid,
  output logic [NUM_SRC-1:0]              s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]       s_tdata,
  input  logic [NUM_SRC*KEEP_STRB_W-1:0]  s_tstrb,
  input  logic [NUM_SRC*KEEP_STRB_W-1:0]  s_tkeep,
  input  logic [NUM_SRC-1:0]              s_tlast,
  input  logic [NUM_SRC*ID_W-1:0]         s_tid,
  input  logic [NUM_SRC*DEST_W-1:0]       s_tdest,
  input  logic [NUM_SRC*USER_W-1:0]       s_tuser,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_W-1:0]               m_tdata,
  output logic [KEEP_STRB_W-1:0]          m_tstrb,
  output logic [KEEP_STRB_W-1:0]          m_tkeep,
  output logic                            m_tlast,
  output logic [ID_W-1:0]                 m_tid,
  output logic [DEST_W-1:0]               m_tdest,
  output logic [USER_W-1:0]               m_tuser,
  output logic                            grant_valid,
  output logic [IDX_W-1:0]                grant_idx,
  output logic [PKT_CNT_W-1:0]            pkt_cnt
);
  arb_state_t state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, pick_idx;
  logic pick_any, busy, last_acc;
  logic [ID_W-1:0] sel_tid;

  axis_rr_picker #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_picker (
    .req(s_tvalid),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign busy = state == BUSY;
  assign grant_valid = busy;
  assign last_acc = m_tvalid & m_tready & m_tlast;

  // mux the granted source onto the master; handshakes only pass while BUSY
  always_comb begin
    m_tvalid = busy & s_tvalid[grant_idx];
    s_tready = busy ? NUM_SRC'(m_tready) << grant_idx : '0;
    m_tdata = s_tdata[grant_idx*DATA_W +: DATA_W];
    m_tstrb = s_tstrb[grant_idx*KEEP_STRB_W +: KEEP_STRB_W];
    m_tkeep = s_tkeep[grant_idx*KEEP_STRB_W +: KEEP_STRB_W];
    m_tlast = s_tlast[grant_idx];
    m_tdest = s_tdest[grant_idx*DEST_W +: DEST_W];
    m_tuser = s_tuser[grant_idx*USER_W +: USER_W];
    sel_tid = s_tid[grant_idx*ID_W +: ID_W];
  end

`ifdef AXIS_ARB_TID_TAG_EN
  if (ID_W < IDX_W) begin : g_bad_id_w
    $error("ID_W must be at least IDX_W to carry the source tag");
  end else if (ID_W == IDX_W) begin : g_tag_full
    assign m_tid = grant_idx;
  end else begin : g_tag
    assign m_tid = {sel_tid[ID_W-1:IDX_W], grant_idx};
  end
`else
  assign m_tid = sel_tid;
`endif

  // state register; grant latched on IDLE->BUSY, pointer and counter advance on accepted TLAST
  always_ff @(posedge ACLK)
    if (ARESET) begin
      state <= IDLE;
      rr_ptr <= IDX_W'(NUM_SRC - 1);
      grant_idx <= '0;
      pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!busy && pick_any) grant_idx <= pick_idx;
      if (last_acc) begin
        rr_ptr <= grant_idx;
        pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
      end
    end

  // next state: any request starts a packet, accepted TLAST ends it
  always_comb begin
    state_nxt = busy ? (last_acc ? IDLE : BUSY) : (pick_any ? BUSY : IDLE);
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: table vectors, corner sequences and random traffic against a packet-level model
module tb_axis_rr_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = 4;
  localparam int XW = 2;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [N-1:0] s_tvalid = '0;
  logic [N-1:0] s_tlast = '0;
  logic [N-1:0] s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tstrb, s_tkeep;
  logic [N*IW-1:0] s_tid;
  logic [N*4-1:0] s_tdest;
  logic [N-1:0] s_tuser;
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tstrb, m_tkeep;
  logic [IW-1:0] m_tid;
  logic [3:0] m_tdest;
  logic [0:0] m_tuser;
  logic grant_valid;
  logic [XW-1:0] grant_idx;
  logic [15:0] pkt_cnt;

  logic [DW-1:0] d [N];
  logic [IW-1:0] tid [N];
  int beat [N], len [N], pk [N];
  int errors = 0, checks = 0;
  int owner, mptr, mg, mcnt;
  logic [N-1:0] acc;
  logic [7:0] got [$];
  int gq [$];
  logic prev_gv;

  typedef struct {
    logic [N-1:0] v, l;
    logic rdy, gv;
    logic [XW-1:0] g;
    logic mv;
    logic [N-1:0] sr;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [17];

  always #5 ACLK = ~ACLK;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_tdata[i*DW +: DW] = d[i];
    assign s_tstrb[i*KW +: KW] = d[i][3:0];
    assign s_tkeep[i*KW +: KW] = d[i][7:4];
    assign s_tdest[i*4 +: 4] = d[i][11:8];
    assign s_tuser[i] = d[i][16];
    assign s_tid[i*IW +: IW] = tid[i];
  end

  axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ID_W(IW), .DEST_W(4), .USER_W(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .pkt_cnt(pkt_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] exp_tid(input int o);
`ifdef AXIS_ARB_TID_TAG_EN
    return {tid[o][IW-1:XW], XW'(o)};
`else
    return tid[o];
`endif
  endfunction

  task automatic model_reset();
    owner = -1;
    mptr = N - 1;
    mg = 0;
    mcnt = 0;
  endtask

  // compare outputs at the falling edge, then advance the packet-level model across the rising edge
  task automatic cyc();
    @(negedge ACLK);
    chk("grant_valid", grant_valid, owner >= 0);
    chk("grant_idx", grant_idx, mg);
    chk("pkt_cnt", pkt_cnt, mcnt);
    chk("s_tready", s_tready, (owner >= 0 && m_tready) ? (1 << owner) : 0);
    chk("m_tvalid", m_tvalid, owner >= 0 ? s_tvalid[owner] : 1'b0);
    if (owner >= 0 && s_tvalid[owner]) begin
      chk("m_tdata", m_tdata, d[owner]);
      chk("m_side", {m_tlast, m_tuser, m_tdest, m_tkeep, m_tstrb},
          {s_tlast[owner], d[owner][16], d[owner][11:8], d[owner][7:4], d[owner][3:0]});
      chk("m_tid", m_tid, exp_tid(owner));
    end
    acc = '0;
    if (ARESET) model_reset();
    else if (owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (s_tvalid[(mptr + k) % N]) begin
          mg = (mptr + k) % N;
          break;
        end
      if (|s_tvalid) owner = mg;
    end else if (s_tvalid[owner] && m_tready) begin
      acc[owner] = 1'b1;
      got.push_back(m_tdata[15:8]);
      if (s_tlast[owner]) begin
        mptr = owner;
        mcnt = (mcnt + 1) % 65536;
        owner = -1;
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic new_beat(input int i);
    d[i] = {8'(i), 8'(pk[i]), 8'(beat[i]), 8'($urandom)};
    tid[i] = 4'($urandom);
    s_tlast[i] = beat[i] == len[i] - 1;
  endtask

  task automatic src_init(input int i, input int l, input logic v);
    beat[i] = 0;
    len[i] = l;
    pk[i]++;
    s_tvalid[i] = v;
    new_beat(i);
  endtask

  // mode 0: random packets and gaps, 1: back-to-back packets, 2: one packet then idle
  task automatic src_update(input int mode);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (s_tlast[i]) begin
          beat[i] = 0;
          pk[i]++;
          if (mode == 0) len[i] = $urandom_range(1, 4);
          s_tvalid[i] = mode == 1 || (mode == 0 && $urandom_range(0, 2) != 0);
        end else begin
          beat[i]++;
          if (mode == 0) s_tvalid[i] = $urandom_range(0, 3) != 0;
        end
        new_beat(i);
      end else if (mode == 0 && !s_tvalid[i]) begin
        s_tvalid[i] = $urandom_range(0, 2) == 0;
        new_beat(i);
      end
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    @(posedge ACLK);
    #1;
    model_reset();
    ARESET = 1'b0;
    got.delete();
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 16'd0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1, 16'd0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 16'd1};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2, 16'd1};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0, 4'h0, 16'd2};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 4'h4, 16'd2};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 16'd3};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 4'h8, 16'd3};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 16'd4};
    tbl[9]  = '{4'hF, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0, 16'd4};
    tbl[10] = '{4'hE, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1, 16'd4};
    tbl[11] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1, 16'd4};
    tbl[12] = '{4'hA, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 16'd5};
    tbl[13] = '{4'hA, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2, 16'd5};
    tbl[14] = '{4'hA, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2, 16'd5};
    tbl[15] = '{4'hA, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0, 4'h0, 16'd6};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 4'h8, 16'd6};
    for (int i = 0; i < N; i++) pk[i] = 0;
    model_reset();
    @(posedge ACLK);
    #1;

    // reset held three cycles with every source requesting
    for (int i = 0; i < N; i++) src_init(i, 1, 1'b1);
    repeat (3) cyc();
    ARESET = 1'b0;
    cyc();
    chk("t1_first_gv", grant_valid, 1);
    chk("t1_first_grant", grant_idx, 0);

    // table vectors from a fresh reset
    do_reset();
    for (int r = 0; r < 17; r++) begin
      s_tvalid = tbl[r].v;
      s_tlast = tbl[r].l;
      m_tready = tbl[r].rdy;
      @(negedge ACLK);
      chk($sformatf("vec%0d_gv", r), grant_valid, tbl[r].gv);
      chk($sformatf("vec%0d_g", r), grant_idx, tbl[r].g);
      chk($sformatf("vec%0d_mv", r), m_tvalid, tbl[r].mv);
      chk($sformatf("vec%0d_sr", r), s_tready, tbl[r].sr);
      chk($sformatf("vec%0d_cnt", r), pkt_cnt, tbl[r].cnt);
      @(posedge ACLK);
      #1;
    end

    // fairness: four sources streaming 2-beat packets back to back
    do_reset();
    for (int i = 0; i < N; i++) src_init(i, 2, 1'b1);
    gq.delete();
    prev_gv = 1'b0;
    repeat (18) begin
      cyc();
      src_update(1);
      if (grant_valid && !prev_gv) gq.push_back(int'(grant_idx));
      prev_gv = grant_valid;
    end
    chk("t2_pkt_cnt", pkt_cnt, 6);
    chk("t2_grants", gq.size(), 6);
    for (int j = 0; j < gq.size() && j < 6; j++) chk($sformatf("t2_grant%0d", j), gq[j], j % N);

    // backpressure on a 3-beat src2 packet
    do_reset();
    src_init(2, 3, 1'b1);
    cyc();
    src_update(2);
    cyc();
    src_update(2);
    m_tready = 1'b0;
    repeat (5) begin
      cyc();
      src_update(2);
      chk("t3_data_held", m_tdata, d[2]);
      chk("t3_beat_held", m_tdata[15:8], 1);
      chk("t3_no_ready", s_tready[2], 0);
    end
    m_tready = 1'b1;
    repeat (3) begin
      cyc();
      src_update(2);
    end
    chk("t3_beats", got.size(), 3);
    for (int j = 0; j < got.size() && j < 3; j++) chk($sformatf("t3_order%0d", j), got[j], j);
    chk("t3_pkt_cnt", pkt_cnt, 1);

    // src1 pauses mid-packet while src0 and src3 wait
    do_reset();
    src_init(1, 3, 1'b1);
    cyc();
    src_update(2);
    cyc();
    src_update(2);
    s_tvalid[1] = 1'b0;
    src_init(0, 1, 1'b1);
    src_init(3, 1, 1'b1);
    repeat (4) begin
      cyc();
      chk("t4_hold_gv", grant_valid, 1);
      chk("t4_hold_idx", grant_idx, 1);
    end
    s_tvalid[1] = 1'b1;
    repeat (2) begin
      cyc();
      src_update(2);
    end
    cyc();
    src_update(2);
    chk("t4_next_grant", grant_idx, 3);

    // reset on the second beat of a 4-beat src0 packet
    do_reset();
    src_init(0, 4, 1'b1);
    repeat (2) begin
      cyc();
      src_update(2);
    end
    ARESET = 1'b1;
    cyc();
    chk("t5_mv", m_tvalid, 0);
    chk("t5_sr", s_tready, 0);
    chk("t5_gv", grant_valid, 0);
    chk("t5_cnt0", pkt_cnt, 0);
    ARESET = 1'b0;
    src_init(0, 4, 1'b1);
    repeat (5) begin
      cyc();
      src_update(2);
    end
    chk("t5_cnt1", pkt_cnt, 1);

    // TID passthrough or tagging from src3
    do_reset();
    src_init(3, 1, 1'b1);
    tid[3] = 4'hC;
    cyc();
    src_update(2);
`ifdef AXIS_ARB_TID_TAG_EN
    chk("t6_tid", m_tid, 4'hF);
`else
    chk("t6_tid", m_tid, 4'hC);
`endif
    cyc();
    src_update(2);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) src_init(i, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    repeat (3000) begin
      m_tready = $urandom_range(0, 3) != 0;
      cyc();
      src_update(0);
    end
    chk("rnd_pkt_cnt", pkt_cnt, mcnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
